kbd_mmio_responder: RTL and testbench

Memory-mapped PS/2 keyboard peripheral. It sits on the processor's data-memory bus as a bus responder alongside Memory. It deserialises PS/2 frames from the keyboard into a scancode FIFO, which the processor drains by load instructions. It also drives key_reg with the most recent valid scancode.

---
 rtl/kbd_mmio_responder.sv | 167 ++++++++++++++++
 tb/tb_kbd_mmio_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_mmio_responder.sv
// kbd_mmio_responder: PS/2 keyboard receiver with a scancode FIFO behind a 3-register MMIO window.
// Define KBD_IRQ_EN to add the CTRL irq_en bit and a registered irq output.
module kbd_mmio_responder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        isWrite,
    input  logic [31:0] writeData,
    input  logic        isRead,
    output logic [31:0] RD,
    output logic        hit,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  key_reg,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  csync_q, csync_d;
    logic [1:0]  dsync_q, dsync_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] tmo_q, tmo_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
    logic        ovf_q, ovf_d, perr_q, perr_d;
    logic [7:0]  key_q, key_d;
    logic [31:0] rd_q, rd_d, off, status, ctrl_rd;
    logic        hit_q, hit_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        fall, sbit, push, frame_err, do_push, empty, full, pop;
    logic        sel_data, sel_stat, sel_ctrl, wr_ctrl, clr, flush;
    logic        unused_ok;

    assign fall = csync_q[2] & ~csync_q[1];
    assign sbit = dsync_q[1];
    assign cnt = wr_ptr_q - rd_ptr_q;
    assign empty = cnt == '0;
    assign full = cnt == (AW+1)'(FIFO_DEPTH);
    assign off = address - BASE_ADDR;
    assign sel_data = off == 32'h0;
    assign sel_stat = off == 32'h4;
    assign sel_ctrl = off == 32'h8;
    assign pop = isRead & sel_data & ~empty;
    assign wr_ctrl = isWrite & sel_ctrl;
    assign clr = wr_ctrl & writeData[0];
    assign flush = wr_ctrl & writeData[1];
    assign status = {16'b0, 8'(cnt), 4'b0, full, perr_q, ovf_q, ~empty};
    assign unused_ok = ^writeData[31:2];

    always_comb begin
        csync_d = {csync_q[1:0], ps2_clk};
        dsync_d = {dsync_q[0], ps2_data};
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d = shift_q;
        par_d = par_q;
        tmo_d = (state_q == IDLE || fall) ? 16'd0 : tmo_q + 16'd1;
        push = 1'b0;
        frame_err = 1'b0;
        // A stalled partial frame is abandoned and reported as a frame error
        if (state_q != IDLE && !fall && tmo_q == TIMEOUT) begin
            state_d = IDLE;
            frame_err = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = sbit ? IDLE : DATA;
                    bit_cnt_d = 3'd0;
                end
                DATA: begin
                    shift_d = {sbit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d = sbit;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    push = (^{shift_q, par_q}) & sbit;
                    frame_err = ~push;
                end
            endcase
        end
        do_push = push & ~flush & (~full | pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop);
        ovf_d = (ovf_q & ~clr) | (push & ~flush & full & ~pop);
        perr_d = (perr_q & ~clr) | frame_err;
        key_d = push ? shift_q : key_q;
        rd_d = !isRead ? 32'h0 :
               sel_data ? (empty ? 32'h0 : {24'b0, mem_q[rd_ptr_q[AW-1:0]]}) :
               sel_stat ? status :
               sel_ctrl ? ctrl_rd : 32'h0;
        hit_d = isRead & (sel_data | sel_stat | sel_ctrl);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            csync_q <= '0;
            dsync_q <= '0;
            bit_cnt_q <= '0;
            shift_q <= '0;
            par_q <= 1'b0;
            tmo_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q <= 1'b0;
            perr_q <= 1'b0;
            key_q <= '0;
            rd_q <= '0;
            hit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            csync_q <= csync_d;
            dsync_q <= dsync_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q <= shift_d;
            par_q <= par_d;
            tmo_q <= tmo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q <= ovf_d;
            perr_q <= perr_d;
            key_q <= key_d;
            rd_q <= rd_d;
            hit_q <= hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

`ifdef KBD_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    assign irq_en_d = wr_ctrl ? writeData[2] : irq_en_q;
    assign irq_d = irq_en_q & ~empty;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q <= irq_d;
        end
    end
    assign ctrl_rd = {29'b0, irq_en_q, 2'b0};
    assign irq = irq_q;
`else
    assign ctrl_rd = 32'h0;
    assign irq = 1'b0;
`endif

    assign RD = rd_q;
    assign hit = hit_q;
    assign key_reg = key_q;
endmodule

// File: tb/tb_kbd_mmio_responder.sv
// tb_kbd_mmio_responder: directed plan plus randomized frames and bus traffic against a queue-based model.
module tb_kbd_mmio_responder;
    localparam int          DEPTH = 8;
    localparam logic [15:0] TMO   = 16'd300;
    localparam logic [31:0] BASE  = 32'h0000_FF00;
`ifdef KBD_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] address = '0, writeData = '0, RD;
    logic        isWrite = 1'b0, isRead = 1'b0, hit;
    logic        ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0]  key_reg;
    logic        irq;

    kbd_mmio_responder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .address(address), .isWrite(isWrite),
        .writeData(writeData), .isRead(isRead), .RD(RD), .hit(hit),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .key_reg(key_reg), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [7:0] q[$];
    bit         m_ovf, m_perr, m_irq_en;
    logic [7:0] m_key;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {16'b0, 8'(q.size()), 4'b0, q.size() == DEPTH, m_perr, m_ovf, q.size() != 0};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_perr = 0;
        m_irq_en = 0;
        m_key = 8'h00;
    endtask

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = b[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = (~^d) ^ bad_par;
        send_bits({~bad_stop, p, d, 1'b0}, 11);
        repeat (6) @(negedge clk);
        if (!bad_par && !bad_stop) begin
            m_key = d;
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1;
        end else m_perr = 1;
        check("key_reg", {24'b0, key_reg}, {24'b0, m_key});
    endtask

    task automatic bus(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd);
        @(negedge clk);
        address = a;
        isRead = rd;
        isWrite = wr;
        writeData = wd;
        @(negedge clk);
        isRead = 0;
        isWrite = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        logic [31:0] off, exp;
        bit hit_e;
        off = a - BASE;
        exp = 0;
        hit_e = 0;
        if (off == 0) begin
            hit_e = 1;
            if (q.size() != 0) exp = {24'b0, q.pop_front()};
        end else if (off == 4) begin
            hit_e = 1;
            exp = m_status();
        end else if (off == 8) begin
            hit_e = 1;
            exp = {29'b0, IRQ && m_irq_en, 2'b0};
        end
        bus(a, 1, 0, 0);
        check(tag, RD, exp);
        check({tag, "_hit"}, {31'b0, hit}, {31'b0, hit_e});
    endtask

    task automatic wr_ctrl(input logic [2:0] v);
        bus(BASE + 8, 0, 1, {29'b0, v});
        if (v[0]) begin
            m_ovf = 0;
            m_perr = 0;
        end
        if (v[1]) q.delete();
        m_irq_en = v[2];
    endtask

    task automatic irq_chk();
        repeat (2) @(negedge clk);
        check("irq", {31'b0, irq}, {31'b0, IRQ && m_irq_en && q.size() != 0});
    endtask

    initial begin
        logic [31:0] bad_addr [3];
        bad_addr[0] = BASE + 12;
        bad_addr[1] = BASE - 4;
        bad_addr[2] = BASE + 2;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_RD", RD, 0);
        check("rst_hit", {31'b0, hit}, 0);
        check("rst_key", {24'b0, key_reg}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'h1C, 0, 0);
        rd_chk("t1_status", BASE + 4);
        rd_chk("t1_data", BASE);
        rd_chk("t1_status2", BASE + 4);

        send_frame(8'h5A, 1, 0);
        rd_chk("t2_status", BASE + 4);
        wr_ctrl(3'b001);
        rd_chk("t2_status_clr", BASE + 4);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
        rd_chk("t3_status", BASE + 4);
        for (int i = 0; i < 9; i++) rd_chk("t3_data", BASE);
        wr_ctrl(3'b001);

        send_bits(11'b000_0000_1010, 4);
        repeat (int'(TMO) + 20) @(negedge clk);
        m_perr = 1;
        send_frame(8'h33, 0, 0);
        rd_chk("t4_status", BASE + 4);
        rd_chk("t4_data", BASE);
        rd_chk("t4_empty", BASE);

        wr_ctrl(3'b101);
        send_frame(8'h16, 0, 0);
        irq_chk();
        rd_chk("t6_data", BASE);
        irq_chk();

        send_frame(8'h44, 0, 0);
        send_bits(11'b000_1110_1110, 5);
        @(negedge clk);
        address = BASE + 4;
        isRead = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_RD", RD, 0);
        check("t5_hit", {31'b0, hit}, 0);
        check("t5_key", {24'b0, key_reg}, 0);
        check("t5_irq", {31'b0, irq}, 0);
        @(negedge clk) isRead = 1'b0;
        @(negedge clk) reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        send_frame(8'h29, 0, 0);
        rd_chk("t5_status", BASE + 4);
        rd_chk("t5_data", BASE);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
                4, 5: rd_chk("r_data", BASE);
                6: rd_chk("r_status", BASE + 4);
                7: wr_ctrl({$urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1});
                8: rd_chk("r_ctrl", BASE + 8);
                default: begin
                    bus(BASE + 4 * $urandom_range(0, 1), 0, 1, $urandom);
                    rd_chk("r_miss", bad_addr[$urandom_range(0, 2)]);
                end
            endcase
            irq_chk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
